// File: rtl/puf_challenge_sequencer.sv
// Challenge sequencer for a ring-oscillator PUF: steps RO pair selects through a run,
// gates the oscillators for a fixed window, then compares the frozen counters into a response word.
module puf_challenge_sequencer #(
    parameter int CNT_W    = 12,
    parameter int SEL_W    = 4,
    parameter int NUM_BITS = 8,
    parameter int WINDOW   = 2000,
    parameter int SETTLE   = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [SEL_W-1:0]    base1,
    input  logic [SEL_W-1:0]    base2,
    input  logic [CNT_W-1:0]    counter1_in,
    input  logic [CNT_W-1:0]    counter2_in,
    output logic [SEL_W-1:0]    select1,
    output logic [SEL_W-1:0]    select2,
    output logic                ro_enable,
    output logic                ro_reset,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] response,
    output logic                tie_flag,
    output logic                sat_flag
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_MEASURE = 3'd2;
    localparam logic [2:0] S_SETTLE  = 3'd3;
    localparam logic [2:0] S_COMPARE = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    // One down-counter times CLEAR, MEASURE and SETTLE; it only ever holds duration-1.
    localparam int TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int TMR_W   = $clog2(TMR_MAX);
    localparam int K_W     = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;
    localparam logic [K_W-1:0]   K_LAST   = K_W'(NUM_BITS - 1);

    logic [2:0]          state_q, state_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [K_W-1:0]      k_q, k_d, k_next;
    logic [SEL_W-1:0]    base1_q, base1_d, base2_q, base2_d;
    logic [SEL_W-1:0]    sel1_q, sel1_d, sel2_q, sel2_d;
    logic                en_q, en_d, clr_q, clr_d, busy_q, busy_d, done_q, done_d;
    logic [NUM_BITS-1:0] resp_q, resp_d;
    logic                tie_q, tie_d, sat_q, sat_d;

    logic cmp_gt, cmp_eq, sel_eq, cmp_sat;

    assign cmp_gt  = counter1_in > counter2_in;
    assign cmp_eq  = counter1_in == counter2_in;
    assign sel_eq  = sel1_q == sel2_q;
    assign cmp_sat = (counter1_in == CNT_SAT) || (counter2_in == CNT_SAT);
    assign k_next  = k_q + K_W'(1);

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        k_d     = k_q;
        base1_d = base1_q;
        base2_d = base2_q;
        sel1_d  = sel1_q;
        sel2_d  = sel2_q;
        resp_d  = resp_q;
        tie_d   = tie_q;
        sat_d   = sat_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base1_d = base1;
                    base2_d = base2;
                    sel1_d  = base1;
                    sel2_d  = base2;
                    k_d     = '0;
                    resp_d  = '0;
                    tie_d   = 1'b0;
                    sat_d   = 1'b0;
                    tmr_d   = TMR_W'(1);
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (tmr_q == '0) begin
                    tmr_d   = TMR_W'(WINDOW - 1);
                    state_d = S_MEASURE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_MEASURE: begin
                if (tmr_q == '0) begin
                    tmr_d   = TMR_W'(SETTLE - 1);
                    state_d = S_SETTLE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_SETTLE: begin
                if (tmr_q == '0) begin
                    state_d = S_COMPARE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_COMPARE: begin
                // A pair measured against itself carries no entropy: force 0 and flag it.
                resp_d[k_q] = cmp_gt && !sel_eq;
                tie_d       = tie_q || cmp_eq || sel_eq;
                sat_d       = sat_q || cmp_sat;
                if (k_q == K_LAST) begin
                    state_d = S_DONE;
                end else begin
                    k_d     = k_next;
                    sel1_d  = base1_q + SEL_W'(k_next);
                    sel2_d  = base2_q + SEL_W'(k_next);
                    tmr_d   = TMR_W'(1);
                    state_d = S_CLEAR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        en_d   = (state_d == S_MEASURE);
        clr_d  = (state_d == S_IDLE) || (state_d == S_CLEAR) || (state_d == S_DONE);
        busy_d = (state_d == S_CLEAR) || (state_d == S_MEASURE) ||
                 (state_d == S_SETTLE) || (state_d == S_COMPARE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            k_q     <= '0;
            base1_q <= '0;
            base2_q <= '0;
            sel1_q  <= '0;
            sel2_q  <= '0;
            en_q    <= 1'b0;
            clr_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            resp_q  <= '0;
            tie_q   <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            k_q     <= k_d;
            base1_q <= base1_d;
            base2_q <= base2_d;
            sel1_q  <= sel1_d;
            sel2_q  <= sel2_d;
            en_q    <= en_d;
            clr_q   <= clr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            resp_q  <= resp_d;
            tie_q   <= tie_d;
            sat_q   <= sat_d;
        end
    end

    assign select1   = sel1_q;
    assign select2   = sel2_q;
    assign ro_enable = en_q;
    assign ro_reset  = clr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign response  = resp_q;
    assign tie_flag  = tie_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Bench for puf_challenge_sequencer: a bank of modelled ROs behind each mux, directed
// vector table, hand-written reset/start-while-busy sequences and randomized runs.
module tb_puf_challenge_sequencer;

    localparam int CNT_W    = 12;
    localparam int SEL_W    = 4;
    localparam int NUM_BITS = 8;
    localparam int WINDOW   = 37;
    localparam int SETTLE   = 4;
    localparam int LATENCY  = 1 + NUM_BITS * (2 + WINDOW + SETTLE + 1);

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic                start = 1'b0;
    logic [SEL_W-1:0]    base1 = '0;
    logic [SEL_W-1:0]    base2 = '0;
    logic [CNT_W-1:0]    counter1_in, counter2_in;
    logic [SEL_W-1:0]    select1, select2;
    logic                ro_enable, ro_reset, busy, done, tie_flag, sat_flag;
    logic [NUM_BITS-1:0] response;

    // Frozen count of each RO; while the window is open or the counters are cleared
    // the inputs carry a deliberately wrong value so early/late sampling shows up.
    logic [CNT_W-1:0] ro1 [16];
    logic [CNT_W-1:0] ro2 [16];

    assign counter1_in = (ro_enable || ro_reset) ? ~ro1[select1] : ro1[select1];
    assign counter2_in = (ro_enable || ro_reset) ? ~ro2[select2] : ro2[select2];

    puf_challenge_sequencer #(
        .CNT_W(CNT_W), .SEL_W(SEL_W), .NUM_BITS(NUM_BITS), .WINDOW(WINDOW), .SETTLE(SETTLE)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .base1(base1), .base2(base2),
        .counter1_in(counter1_in), .counter2_in(counter2_in),
        .select1(select1), .select2(select2), .ro_enable(ro_enable), .ro_reset(ro_reset),
        .busy(busy), .done(done), .response(response), .tie_flag(tie_flag), .sat_flag(sat_flag)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] b1;
        logic [3:0] b2;
        int         pat;
        int         extra;
        logic [7:0] resp;
        logic       tie;
        logic       sat;
    } vec_t;

    vec_t tbl[5];

    task automatic load_pat(input int pat);
        for (int i = 0; i < 16; i++) begin
            case (pat)
                0: begin ro1[i] = 12'd1500; ro2[i] = 12'd1400; end
                1: begin ro1[i] = 12'd1000; ro2[i] = (i % 2 == 1) ? 12'd900 : 12'd1100; end
                2: begin ro1[i] = 12'd1500; ro2[i] = 12'd1400; end
                default: begin
                    ro1[i] = ($urandom_range(0, 15) == 0) ? 12'hFFF : 12'($urandom_range(1000, 1007));
                    ro2[i] = ($urandom_range(0, 15) == 0) ? 12'hFFF : 12'($urandom_range(1000, 1007));
                end
            endcase
        end
        if (pat == 2) begin
            ro1[2] = 12'd800;
            ro2[3] = 12'd800;
            ro1[5] = 12'hFFF;
        end
    endtask

    // Reference: bit k compares the RO pair at (base+k) mod 16 on each side.
    task automatic model(input logic [3:0] b1, input logic [3:0] b2,
                         output logic [7:0] r, output logic t, output logic s);
        logic [3:0] s1, s2;
        r = '0; t = 1'b0; s = 1'b0;
        for (int k = 0; k < NUM_BITS; k++) begin
            s1 = b1 + 4'(k);
            s2 = b2 + 4'(k);
            r[k] = (s1 != s2) && (ro1[s1] > ro2[s2]);
            t = t || (s1 == s2) || (ro1[s1] == ro2[s2]);
            s = s || (ro1[s1] == 12'hFFF) || (ro2[s2] == 12'hFFF);
        end
    endtask

    // Starts a run, watches every cycle until done, then checks result and framing.
    task automatic run_check(input string tag, input logic [3:0] b1, input logic [3:0] b2,
                             input int extra, input logic [7:0] er, input logic et, input logic es);
        int cyc = 0, k_seen = 0, en_run = 0, clr_cnt = 0, both = 0, idle_busy = 0;
        logic prev_en = 1'b0;
        logic [3:0] xs1 = '0, xs2 = '0;
        bit got_done = 0;
        @(negedge clock);
        base1 = b1; base2 = b2; start = 1'b1;
        while (!got_done && cyc < LATENCY + 20) begin
            @(negedge clock);
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (extra != 0 && cyc == extra) begin
                start = 1'b1; base1 = ~b1; base2 = b1;
            end
            if (extra != 0 && cyc == extra + 1) start = 1'b0;
            if (done) begin
                got_done = 1;
            end else begin
                if (!busy) idle_busy++;
                if (ro_enable && ro_reset) both++;
                if (busy && ro_reset) clr_cnt++;
                if (ro_enable && !prev_en) begin
                    xs1 = b1 + 4'(k_seen);
                    xs2 = b2 + 4'(k_seen);
                    chk({tag, "_sel1"}, 32'(select1), 32'(xs1));
                    chk({tag, "_sel2"}, 32'(select2), 32'(xs2));
                    k_seen++;
                end
                if (ro_enable) en_run++;
                if (!ro_enable && prev_en) begin
                    chk({tag, "_window"}, 32'(en_run), 32'(WINDOW));
                    chk({tag, "_sel_hold"}, 32'({select1, select2}), 32'({xs1, xs2}));
                    en_run = 0;
                end
                prev_en = ro_enable;
            end
        end
        if (!got_done) begin
            chk({tag, "_done_timeout"}, 32'(cyc), 32'(LATENCY));
            return;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(LATENCY));
        chk({tag, "_response"}, 32'(response), 32'(er));
        chk({tag, "_tie"}, 32'(tie_flag), 32'(et));
        chk({tag, "_sat"}, 32'(sat_flag), 32'(es));
        chk({tag, "_bits_measured"}, 32'(k_seen), 32'(NUM_BITS));
        chk({tag, "_clear_cycles"}, 32'(clr_cnt), 32'(2 * NUM_BITS));
        chk({tag, "_en_and_clr"}, 32'(both), 32'd0);
        chk({tag, "_busy_gap"}, 32'(idle_busy), 32'd0);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk({tag, "_post_done"}, 32'({done, busy}), 32'd0);
        @(negedge clock);
        chk({tag, "_hold"}, 32'({response, tie_flag, sat_flag, busy}), 32'({er, et, es, 1'b0}));
    endtask

    initial begin
        logic [7:0] mr;
        logic       mt, ms;
        logic [3:0] rb1, rb2;

        tbl[0] = '{b1: 4'd0,  b2: 4'd1, pat: 0, extra: 0,   resp: 8'hFF, tie: 1'b0, sat: 1'b0};
        tbl[1] = '{b1: 4'd14, b2: 4'd3, pat: 1, extra: 0,   resp: 8'h55, tie: 1'b0, sat: 1'b0};
        tbl[2] = '{b1: 4'd0,  b2: 4'd1, pat: 2, extra: 0,   resp: 8'hFB, tie: 1'b1, sat: 1'b1};
        tbl[3] = '{b1: 4'd7,  b2: 4'd7, pat: 2, extra: 0,   resp: 8'h00, tie: 1'b1, sat: 1'b0};
        tbl[4] = '{b1: 4'd0,  b2: 4'd1, pat: 0, extra: 100, resp: 8'hFF, tie: 1'b0, sat: 1'b0};
        load_pat(0);

        // Reset held while start toggles: nothing may leave idle.
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            start = ~start;
            base1 = 4'(i);
        end
        start = 1'b0;
        chk("reset_ctrl", 32'({ro_reset, ro_enable, busy, done}), 32'b1000);
        chk("reset_data", 32'({response, tie_flag, sat_flag}), 32'd0);
        chk("reset_sel", 32'({select1, select2}), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("idle_after_reset", 32'({ro_reset, ro_enable, busy}), 32'b100);

        for (int v = 0; v < 5; v++) begin
            load_pat(tbl[v].pat);
            run_check($sformatf("vec%0d", v), tbl[v].b1, tbl[v].b2, tbl[v].extra,
                      tbl[v].resp, tbl[v].tie, tbl[v].sat);
        end

        // Asynchronous reset in the middle of bit 3's window.
        load_pat(0);
        @(negedge clock);
        base1 = 4'd0; base2 = 4'd1; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        begin
            int rises = 0, guard = 0;
            logic prev = 1'b0;
            while (rises < 4 && guard < LATENCY) begin
                @(negedge clock);
                guard++;
                if (ro_enable && !prev) rises++;
                prev = ro_enable;
            end
            chk("midrun_reached_k3", 32'(rises), 32'd4);
        end
        repeat (5) @(negedge clock);
        chk("midrun_partial", 32'({ro_enable, response}), 32'({1'b1, 8'h07}));
        #2 reset = 1'b0;
        #1;
        chk("midrun_reset_ctrl", 32'({ro_enable, ro_reset, busy, done}), 32'b0100);
        chk("midrun_reset_data", 32'({response, select1, select2}), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        run_check("after_reset", 4'd0, 4'd1, 0, 8'hFF, 1'b0, 1'b0);

        // Random RO banks and bases against the reference model.
        for (int r = 0; r < 5; r++) begin
            load_pat(9);
            rb1 = 4'($urandom_range(0, 15));
            rb2 = (r == 4) ? rb1 : 4'($urandom_range(0, 15));
            model(rb1, rb2, mr, mt, ms);
            run_check($sformatf("rand%0d", r), rb1, rb2, 0, mr, mt, ms);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
